// File: rtl/ilk_lane_pkg.sv
// ilk_lane_pkg: shared Interlaken lane constants, framer states and the 64-bit scrambler step.
package ilk_lane_pkg;
    localparam int POLY_W = 58;
    localparam int WORD_W = 64;
    localparam logic [WORD_W-1:0] DEF_SYNC_WORD = 64'h78f6_78f6_78f6_78f6;
    localparam logic [5:0] DEF_STATE_TAG = 6'b001010;
    localparam logic [5:0] DEF_DIAG_TAG = 6'b011001;

    typedef enum logic [1:0] {SYNC, SSTATE, PAYLOAD, DIAG} mf_state_t;

    // x^58+x^39+1 advanced 64 bits; [63:58] are keystream bits beyond poly, [57:0] the new state
    function automatic logic [WORD_W-1:0] ilk_scr_next(input logic [POLY_W-1:0] poly);
        return {poly, poly[57:52]} ^ {poly[38:0], poly[38:14]} ^ {39'b0, poly[57:39], 6'b0};
    endfunction
endpackage

// File: rtl/ilk_scr_lfsr.sv
// ilk_scr_lfsr: x^58+x^39+1 scrambler state with lane seed load and 64-bit advance.
module ilk_scr_lfsr
    import ilk_lane_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        seed,
    input  logic              adv,
    output logic [POLY_W-1:0] poly,
    output logic [WORD_W-1:0] ks
);
    logic [WORD_W-1:0] nxt;
    assign nxt = ilk_scr_next(poly);
    assign ks = {poly, nxt[WORD_W-1:POLY_W]};
    always_ff @(posedge clk) begin
        if (reset) poly <= {{(POLY_W-4){1'b1}}, seed};
        else if (adv) poly <= nxt[POLY_W-1:0];
    end
endmodule

// File: rtl/ilk_metaframe_scrambler.sv
// ilk_metaframe_scrambler: Interlaken lane metaframe builder (sync, state, scrambled payload, diag).
// Define ILK_SCR_ERR_INJECT_EN to add err_inject, which flips bit 0 of the next sync word.
module ilk_metaframe_scrambler
    import ilk_lane_pkg::*;
#(
    parameter int                METAFRAME_LEN = 2048,
    parameter logic [WORD_W-1:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter logic [5:0]        STATE_TAG     = DEF_STATE_TAG,
    parameter logic [5:0]        DIAG_TAG      = DEF_DIAG_TAG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        lane_id,
    input  logic [1:0]        lane_status,
`ifdef ILK_SCR_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_ctl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_ctl
);
    localparam int WC_W = $clog2(METAFRAME_LEN);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(METAFRAME_LEN - 4);

    mf_state_t         state;
    logic [WC_W-1:0]   wc;
    logic [POLY_W-1:0] poly;
    logic [WORD_W-1:0] ks, sync_word;
    logic              load, take, adv;

    assign load = !out_valid | out_ready;
    assign in_ready = !reset & load & (state == PAYLOAD);
    assign take = in_ready & in_valid;
    assign adv = take | (!reset & load & (state == DIAG));

    ilk_scr_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (lane_id),
        .adv   (adv),
        .poly  (poly),
        .ks    (ks)
    );

`ifdef ILK_SCR_ERR_INJECT_EN
    logic err_arm;
    always_ff @(posedge clk) begin
        if (reset) err_arm <= 1'b0;
        else err_arm <= (err_arm & !(load & (state == SYNC))) | err_inject;
    end
    assign sync_word = SYNC_WORD ^ {{(WORD_W-1){1'b0}}, err_arm};
`else
    assign sync_word = SYNC_WORD;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
            wc <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_ctl <= 1'b0;
        end else if (load) begin
            case (state)
                SYNC: begin
                    out_valid <= 1'b1;
                    out_data <= sync_word;
                    out_ctl <= 1'b1;
                    state <= SSTATE;
                end
                SSTATE: begin
                    out_valid <= 1'b1;
                    out_data <= {STATE_TAG, poly};
                    out_ctl <= 1'b1;
                    wc <= '0;
                    state <= PAYLOAD;
                end
                PAYLOAD: begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        out_data <= in_data ^ ks;
                        out_ctl <= in_ctl;
                        wc <= wc + 1'b1;
                        if (wc == WC_LAST) state <= DIAG;
                    end
                end
                DIAG: begin
                    out_valid <= 1'b1;
                    out_data <= {DIAG_TAG, 56'h0, lane_status} ^ ks;
                    out_ctl <= 1'b1;
                    wc <= '0;
                    state <= SYNC;
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: doc/ilk_metaframe_scrambler.md
Name: ilk_metaframe_scrambler

Overview:
- Parametrised Interlaken lane transmit framer/scrambler: x^58+x^39+1, 64 bits per word, self-synchronous state-word scheme.
- Builds complete metaframes: sync word, scrambler-state word, scrambled payload, then a scrambled diagnostic word.
- Uses valid/ready handshakes on both sides and stalls upstream during control-word insertion.
- Sits between the lane striper and the 64b/67b encoder.

Parameters:
- METAFRAME_LEN, 2048: words per metaframe including 3 overhead words; legal range 4..65535.
- SYNC_WORD, 64'h78f678f678f678f6: sync word pattern.
- STATE_TAG, 6'b001010: top 6 bits of the scrambler-state word.
- DIAG_TAG, 6'b011001: top 6 bits of the diagnostic word.

Ports:
- clk  in  1  clock
- reset  in  1  reset (see Behaviour)
- lane_id  in  4  seed low nibble; sampled only while reset=1
- lane_status  in  2  copied into diagnostic word bits [1:0]
- in_valid  in  1  upstream payload word valid
- in_ready  out  1  payload word accepted when in_valid & in_ready
- in_data  in  64  payload word
- in_ctl  in  1  payload control/data flag, passed through
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  64  framed/scrambled word
- out_ctl  out  1  1 = control word

Behaviour:
- Reset:
  - reset is synchronous, active-high; clock clk.
  - During reset: Poly <= {54'h3F_FFFF_FFFF_FFFF, lane_id}; state=SYNC; wc=0; out_valid=0; out_data=0; out_ctl=0; in_ready=0.
  - Reset mid-operation discards the output register and the partial metaframe, with no flush.
- Keystream:
  - next = Poly advanced 64 bits: {Poly,Poly[57:52]} ^ {Poly[38:0],Poly[38:14]} ^ {39'b0,Poly[57:39],6'b0}.
  - ks = {Poly, next[63:58]}.
  - Poly <= next[57:0] only when a scrambled word (payload or diagnostic) loads the output register.
- Output register:
  - load = !out_valid | out_ready.
  - One output stage; data-to-output latency is 1 cycle.
  - Held stable while out_valid & !out_ready.
- FSM states and transitions (each state advances only when load=1):
  - SYNC: out_data=SYNC_WORD, ctl=1, no scrambling -> SSTATE.
  - SSTATE: out_data={STATE_TAG, Poly}, ctl=1, no scrambling -> PAYLOAD; wc=0.
  - PAYLOAD:
    - in_ready=load. On in_valid&in_ready: out_data=in_data^ks, out_ctl=in_ctl, wc++.
    - When wc reaches METAFRAME_LEN-3 after the increment -> DIAG.
    - No in_valid: out_valid drops to 0 after the current word drains; no idle insertion.
  - DIAG: out_data={DIAG_TAG,56'h0,lane_status}^ks, ctl=1 -> SYNC.
- in_ready is 0 in SYNC, SSTATE and DIAG.
- wc width is $clog2(METAFRAME_LEN). It wraps only through the DIAG->SYNC path.
- Simultaneous out_ready and an upstream word: accept and load in the same cycle, giving full throughput.
- Payload throughput is (METAFRAME_LEN-3)/METAFRAME_LEN.

Optional Feature:
- Macro: ILK_SCR_ERR_INJECT_EN.
- Defined:
  - Extra input port err_inject (1 bit).
  - A pulse arms a sticky flag; the next SYNC word goes out with bit 0 inverted, then the flag clears.
  - Reset clears the flag.
  - Used to test receiver word-lock loss.
- Undefined: the port does not exist and the sync word is always exact.

Decomposition:
- Package ilk_lane_pkg:
  - constants POLY_W=58, WORD_W=64, default SYNC_WORD, STATE_TAG, DIAG_TAG;
  - enum mf_state_t {SYNC,SSTATE,PAYLOAD,DIAG};
  - function ilk_scr_next(Poly) returning 64-bit next.
- Sub-module ilk_scr_lfsr: holds Poly, provides seed load and advance, outputs ks and Poly. Shared with the future descrambler.

Test Plan:
- Reset, lane_id=2, METAFRAME_LEN=8, out_ready=1 -> words 1-2: 64'h78f678f678f678f6 ctl=1, 64'h2BFF_FFFF_FFFF_FFF2 ctl=1.
- Zero payload after the above -> first payload word 64'hFFFF_FFFF_FFFF_FC80; next 4 words match a bit-serial x^58+x^39+1 reference model.
- METAFRAME_LEN=8, continuous input -> 5 payload, DIAG (descrambled top 6 = 011001, low 2 = lane_status), then SYNC. Check wrap over 3 metaframes; state word equals model Poly.
- Random out_ready (50%) and in_valid -> out_data/out_ctl stable during stalls; no lost or duplicate payload; count of in_ready&in_valid per metaframe equals METAFRAME_LEN-3.
- Assert reset mid-payload (wc=3) -> next output after release is SYNC, then state word 64'h2BFF_FFFF_FFFF_FFF2.
- ILK_SCR_ERR_INJECT_EN: pulse err_inject -> next sync = 64'h78f678f678f678f7; the following sync is exact.
